multicycle_control_fsm: RTL and testbench

Main controller for the multicycle RV32I core. Sequences fetch, decode, execute, memory and write-back over several cycles from the instruction-register opcode. It drives the datapath select/strobe signals and the 2-bit `alu_op` consumed by the ALU decoder, which combines it with funct3/funct7 to form `alu_ctrl`. Supports lw, sw, R-type, I-type ALU, beq/blt/bge and jal.

---
 rtl/multicycle_control_fsm_pkg.sv | 47 ++++
 rtl/multicycle_control_fsm_if.sv | 33 +++
 rtl/multicycle_control_fsm.sv | 145 ++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_fsm_pkg.sv
// Shared definitions for the multicycle RV32I main controller: state encoding,
// opcode constants and datapath select encodings (package control_pkg).
package control_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT  = 2'b10;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
  localparam logic [1:0] SRC_A_RS1    = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] RES_ALU_OUT    = 2'b00;
  localparam logic [1:0] RES_READ_DATA  = 2'b01;
  localparam logic [1:0] RES_ALU_RESULT = 2'b10;

  function automatic logic is_supported(input logic [6:0] op);
    return (op == OP_LOAD)  || (op == OP_STORE) || (op == OP_RTYPE) ||
           (op == OP_ITYPE) || (op == OP_JAL)   || (op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Controller <-> datapath bundle. master = controller, slave = datapath side.
interface multicycle_control_fsm_if;

  logic [6:0] opcode;
  logic       mem_ready;
  logic [1:0] alu_op;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic       adr_src;
  logic       ir_write;
  logic       pc_update;
  logic       reg_write;
  logic       mem_write;
  logic       branch;
  logic       illegal_instr;
  logic [3:0] state;

  modport master (
    input  opcode, mem_ready,
    output alu_op, alu_src_a, alu_src_b, result_src, adr_src,
           ir_write, pc_update, reg_write, mem_write, branch,
           illegal_instr, state
  );

  modport slave (
    output opcode, mem_ready,
    input  alu_op, alu_src_a, alu_src_b, result_src, adr_src,
           ir_write, pc_update, reg_write, mem_write, branch,
           illegal_instr, state
  );

endinterface

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I main controller (Moore FSM). Define MCFSM_MEM_WAIT_EN to make
// FETCH/MEMREAD/MEMWRITE hold until mem_ready.
//
// state      | meaning
// -----------+-----------------------------------------------
// FETCH      | IR <- mem[PC], PC <- PC+4
// DECODE     | read regs, precompute PC+imm, dispatch by opcode
// MEMADR     | rs1 + imm load/store address
// MEMREAD    | load data read
// MEMWB      | load data -> rd
// MEMWRITE   | store data write
// EXECUTER   | rs1 op rs2
// EXECUTEI   | rs1 op imm
// ALUWB      | ALU-out register -> rd
// JAL        | PC <- target, link value PC+4
// BRANCH     | rs1 compare rs2, conditional PC write
module multicycle_control_fsm
  import control_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  multicycle_control_fsm_if.master ctrl
);

  state_t state_q;
  state_t state_d;
  logic   mem_done;

`ifdef MCFSM_MEM_WAIT_EN
  assign mem_done = ctrl.mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = ctrl.mem_ready;
  assign mem_done = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_done) state_d = S_DECODE;
      S_DECODE: begin
        case (ctrl.opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECUTER;
          OP_ITYPE:          state_d = S_EXECUTEI;
          OP_JAL:            state_d = S_JAL;
          OP_BRANCH:         state_d = S_BRANCH;
          default:           state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = ctrl.opcode[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_done) state_d = S_MEMWB;
      S_MEMWRITE: if (mem_done) state_d = S_FETCH;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_JAL:      state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  logic [1:0] alu_op_s, src_a_s, src_b_s, result_src_s;
  logic       adr_src_s, ir_write_s, pc_update_s, reg_write_s;
  logic       mem_write_s, branch_s, illegal_s;

  always_comb begin
    alu_op_s     = ALU_OP_ADD;
    src_a_s      = SRC_A_PC;
    src_b_s      = SRC_B_RS2;
    result_src_s = RES_ALU_OUT;
    adr_src_s    = 1'b0;
    ir_write_s   = 1'b0;
    pc_update_s  = 1'b0;
    reg_write_s  = 1'b0;
    mem_write_s  = 1'b0;
    branch_s     = 1'b0;
    illegal_s    = 1'b0;
    case (state_q)
      S_FETCH: begin
        src_b_s      = SRC_B_FOUR;
        result_src_s = RES_ALU_RESULT;
        ir_write_s   = mem_done;
        pc_update_s  = mem_done;
      end
      S_DECODE: begin
        src_a_s   = SRC_A_OLD_PC;
        src_b_s   = SRC_B_IMM;
        illegal_s = !is_supported(ctrl.opcode);
      end
      S_MEMADR: begin
        src_a_s = SRC_A_RS1;
        src_b_s = SRC_B_IMM;
      end
      S_MEMREAD:  adr_src_s = 1'b1;
      S_MEMWB: begin
        result_src_s = RES_READ_DATA;
        reg_write_s  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src_s   = 1'b1;
        mem_write_s = 1'b1;
      end
      S_EXECUTER: begin
        src_a_s  = SRC_A_RS1;
        alu_op_s = ALU_OP_FUNCT;
      end
      S_EXECUTEI: begin
        src_a_s  = SRC_A_RS1;
        src_b_s  = SRC_B_IMM;
        alu_op_s = ALU_OP_FUNCT;
      end
      S_ALUWB:    reg_write_s = 1'b1;
      S_JAL: begin
        src_a_s     = SRC_A_OLD_PC;
        src_b_s     = SRC_B_FOUR;
        pc_update_s = 1'b1;
      end
      S_BRANCH: begin
        src_a_s  = SRC_A_RS1;
        alu_op_s = ALU_OP_BRANCH;
        branch_s = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes are gated by rst so none can fire while reset is asserted.
  assign ctrl.alu_op        = alu_op_s;
  assign ctrl.alu_src_a     = src_a_s;
  assign ctrl.alu_src_b     = src_b_s;
  assign ctrl.result_src    = result_src_s;
  assign ctrl.adr_src       = adr_src_s;
  assign ctrl.ir_write      = ir_write_s  & ~rst;
  assign ctrl.pc_update     = pc_update_s & ~rst;
  assign ctrl.reg_write     = reg_write_s & ~rst;
  assign ctrl.mem_write     = mem_write_s & ~rst;
  assign ctrl.branch        = branch_s    & ~rst;
  assign ctrl.illegal_instr = illegal_s   & ~rst;
  assign ctrl.state         = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: per-instruction vector table,
// randomized instruction stream against a phase-list model, reset/wait corners.
module tb_multicycle_control_fsm;
  import control_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_control_fsm_if bus ();
  multicycle_control_fsm dut (.clk(clk), .rst(rst), .ctrl(bus.master));

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [3:0] st;
    logic [1:0] alu_op, a, b, rs;
    logic       adr, irw, pcu, rw, mw, br, ill;
  } obs_t;

  typedef struct {
    logic [6:0] op;
    int cyc, rw, mw, ill, br;
  } vec_t;

  state_t seq_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.st = bus.state; o.alu_op = bus.alu_op; o.a = bus.alu_src_a; o.b = bus.alu_src_b;
    o.rs = bus.result_src; o.adr = bus.adr_src; o.irw = bus.ir_write; o.pcu = bus.pc_update;
    o.rw = bus.reg_write; o.mw = bus.mem_write; o.br = bus.branch; o.ill = bus.illegal_instr;
    return o;
  endfunction

  // mem_ready as the controller should see it in this build
  function automatic logic eff_mr(input logic mr);
`ifdef MCFSM_MEM_WAIT_EN
    return mr;
`else
    return 1'b1;
`endif
  endfunction

  // Output table straight from the per-state listing; unlisted outputs are 0.
  function automatic obs_t expect_of(input state_t ph, input logic ill, input logic mr);
    obs_t e = '0;
    e.st = ph;
    case (ph)
      S_FETCH:    begin e.b = 2'b10; e.rs = 2'b10; e.irw = mr; e.pcu = mr; end
      S_DECODE:   begin e.a = 2'b01; e.b = 2'b01; e.ill = ill; end
      S_MEMADR:   begin e.a = 2'b10; e.b = 2'b01; end
      S_MEMREAD:  e.adr = 1'b1;
      S_MEMWB:    begin e.rs = 2'b01; e.rw = 1'b1; end
      S_MEMWRITE: begin e.adr = 1'b1; e.mw = 1'b1; end
      S_EXECUTER: begin e.a = 2'b10; e.alu_op = 2'b10; end
      S_EXECUTEI: begin e.a = 2'b10; e.b = 2'b01; e.alu_op = 2'b10; end
      S_ALUWB:    e.rw = 1'b1;
      S_JAL:      begin e.a = 2'b01; e.b = 2'b10; e.pcu = 1'b1; end
      S_BRANCH:   begin e.a = 2'b10; e.alu_op = 2'b01; e.br = 1'b1; end
      default:    ;
    endcase
    return e;
  endfunction

  // Ordered phase list an instruction walks through, by instruction class.
  function automatic void load_seq(input logic [6:0] op);
    seq_q.delete();
    seq_q.push_back(S_FETCH);
    seq_q.push_back(S_DECODE);
    if (op == 7'b0000011) begin
      seq_q.push_back(S_MEMADR); seq_q.push_back(S_MEMREAD); seq_q.push_back(S_MEMWB);
    end else if (op == 7'b0100011) begin
      seq_q.push_back(S_MEMADR); seq_q.push_back(S_MEMWRITE);
    end else if (op == 7'b0110011) begin
      seq_q.push_back(S_EXECUTER); seq_q.push_back(S_ALUWB);
    end else if (op == 7'b0010011) begin
      seq_q.push_back(S_EXECUTEI); seq_q.push_back(S_ALUWB);
    end else if (op == 7'b1101111) begin
      seq_q.push_back(S_JAL); seq_q.push_back(S_ALUWB);
    end else if (op == 7'b1100011) begin
      seq_q.push_back(S_BRANCH);
    end
  endfunction

  // Starts in FETCH just after a rising edge; ends in the next FETCH.
  task automatic run_instr(input logic [6:0] op, input bit rand_mr,
                           output int cycles, output int n_rw, output int n_mw,
                           output int n_ill, output int n_br);
    int   idx = 0;
    logic mr, illegal;
    obs_t got, exp;
    cycles = 0; n_rw = 0; n_mw = 0; n_ill = 0; n_br = 0;
    bus.opcode = op;
    load_seq(op);
    illegal = (seq_q.size() == 2);
    while (idx < seq_q.size()) begin
      if (cycles > 60) begin
        chk("instr_timeout", 32'(cycles), 32'd60);
        break;
      end
      mr = rand_mr ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.mem_ready = mr;
      #1;
      exp = expect_of(seq_q[idx], illegal && (seq_q[idx] == S_DECODE), eff_mr(mr));
      got = sample();
      chk("cycle_outputs", 32'(got), 32'(exp));
      n_rw += int'(got.rw); n_mw += int'(got.mw); n_ill += int'(got.ill); n_br += int'(got.br);
      if (!((seq_q[idx] inside {S_FETCH, S_MEMREAD, S_MEMWRITE}) && !eff_mr(mr))) idx++;
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  vec_t vecs[10];

  initial begin
    int c, rw, mw, il, br;
    logic [6:0] op;
    logic [6:0] ops_ok[6];
    obs_t o;

    vecs[0] = '{7'b0000011, 5, 1, 0, 0, 0};
    vecs[1] = '{7'b0100011, 4, 0, 1, 0, 0};
    vecs[2] = '{7'b0110011, 4, 1, 0, 0, 0};
    vecs[3] = '{7'b0010011, 4, 1, 0, 0, 0};
    vecs[4] = '{7'b1101111, 4, 1, 0, 0, 0};
    vecs[5] = '{7'b1100011, 3, 0, 0, 0, 1};
    vecs[6] = '{7'b0000000, 2, 0, 0, 1, 0};
    vecs[7] = '{7'b1111111, 2, 0, 0, 1, 0};
    vecs[8] = '{7'b0010111, 2, 0, 0, 1, 0};
    vecs[9] = '{7'b0110111, 2, 0, 0, 1, 0};
    ops_ok = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111, 7'b1100011};

    // reset: FETCH selects, all strobes low
    rst = 1'b1; bus.mem_ready = 1'b1; bus.opcode = 7'b0110011;
    #3;
    chk("reset_outputs", 32'(sample()), 32'(expect_of(S_FETCH, 1'b0, 1'b0)));
    @(posedge clk); #2;
    chk("reset_hold", 32'(sample()), 32'(expect_of(S_FETCH, 1'b0, 1'b0)));
    rst = 1'b0;

    // one instruction per table row, mem_ready high
    for (int i = 0; i < 10; i++) begin
      run_instr(vecs[i].op, 1'b0, c, rw, mw, il, br);
      chk($sformatf("vec%0d_cycles", i), 32'(c), 32'(vecs[i].cyc));
      chk($sformatf("vec%0d_counts", i), {rw[7:0], mw[7:0], il[7:0], br[7:0]},
          {8'(vecs[i].rw), 8'(vecs[i].mw), 8'(vecs[i].ill), 8'(vecs[i].br)});
    end

    // branch then the following FETCH advances PC
    run_instr(7'b1100011, 1'b0, c, rw, mw, il, br);
    bus.mem_ready = 1'b1; #1;
    chk("post_branch_fetch_pcu", {28'd0, bus.state}, {28'd0, 4'(S_FETCH)});
    chk("post_branch_fetch_pcu_bit", 32'(bus.pc_update), 32'd1);

    // randomized instruction stream
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) op = 7'($urandom_range(0, 127));
      else                           op = ops_ok[$urandom_range(0, 5)];
      run_instr(op, 1'b1, c, rw, mw, il, br);
    end

    // reset asserted during EXECUTER of an R-type aborts it
    bus.opcode = 7'b0110011; bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_reset_execr", 32'(bus.state), 32'(S_EXECUTER));
    #1 rst = 1'b1;
    #1;
    o = sample();
    chk("async_reset_now", 32'(o), 32'(expect_of(S_FETCH, 1'b0, 1'b0)));
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #2;
      o = sample();
      chk("reset_no_aluwb", {24'd0, o.st, 3'd0, o.rw}, {24'd0, 4'(S_FETCH), 4'd0});
    end
    rst = 1'b0; #1;
    chk("after_reset_fetch", 32'(sample()), 32'(expect_of(S_FETCH, 1'b0, 1'b1)));
    @(posedge clk); #1;
    chk("after_reset_decode", 32'(bus.state), 32'(S_DECODE));
    bus.opcode = 7'b0000000;
    @(posedge clk); #1;
    chk("back_to_fetch", 32'(bus.state), 32'(S_FETCH));

    // mem_ready low for 3 cycles while in FETCH
`ifdef MCFSM_MEM_WAIT_EN
    for (int k = 0; k < 3; k++) begin
      bus.mem_ready = 1'b0; #1;
      o = sample();
      chk("fetch_wait", {o.st, o.irw, o.pcu}, {4'(S_FETCH), 2'b00});
      @(posedge clk); #1;
    end
    bus.mem_ready = 1'b1; #1;
    o = sample();
    chk("fetch_wait_done", {o.st, o.irw, o.pcu}, {4'(S_FETCH), 2'b11});
`else
    bus.mem_ready = 1'b0; #1;
    o = sample();
    chk("fetch_ignores_ready", {o.st, o.irw, o.pcu}, {4'(S_FETCH), 2'b11});
`endif
    @(posedge clk); #1;
    chk("fetch_to_decode", 32'(bus.state), 32'(S_DECODE));
    bus.mem_ready = 1'b1;
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
